// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN calculator sequencing controller:
// command opcodes, ALU opcode constants, completion status and FSM states.
package rpn_pkg;

    typedef enum logic [3:0] {
        CMD_PUSH  = 4'd0,
        CMD_POP   = 4'd1,
        CMD_ADD   = 4'd2,
        CMD_SUB   = 4'd3,
        CMD_SLL   = 4'd4,
        CMD_SRL   = 4'd5,
        CMD_SLTU  = 4'd6,
        CMD_AND   = 4'd7,
        CMD_OR    = 4'd8,
        CMD_NOR   = 4'd9,
        CMD_XOR   = 4'd10,
        CMD_MULLO = 4'd11,
        CMD_SWAP  = 4'd12
    } rpn_cmd_e;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_XOR   = 4'b0010;
    localparam logic [3:0] ALU_NOR   = 4'b0011;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b0101;
    localparam logic [3:0] ALU_MULTU = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b1000;
    localparam logic [3:0] ALU_SRL   = 4'b1001;
    localparam logic [3:0] ALU_SLTU  = 4'b1101;

    typedef enum logic [1:0] {
        ST_OK  = 2'd0,
        ST_OVF = 2'd1,
        ST_UNF = 2'd2
    } rpn_status_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_POP1  = 3'd1,
        S_POP2  = 3'd2,
        S_EXEC  = 3'd3,
        S_PUSH1 = 3'd4,
        S_PUSH2 = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_e;

    // Binary stack command -> ALU opcode; non-ALU commands map to ADD.
    function automatic logic [3:0] cmd_to_aluop(input rpn_cmd_e cmd);
        logic [3:0] op;
        case (cmd)
            CMD_ADD:   op = ALU_ADD;
            CMD_SUB:   op = ALU_SUB;
            CMD_SLL:   op = ALU_SLL;
            CMD_SRL:   op = ALU_SRL;
            CMD_SLTU:  op = ALU_SLTU;
            CMD_AND:   op = ALU_AND;
            CMD_OR:    op = ALU_OR;
            CMD_NOR:   op = ALU_NOR;
            CMD_XOR:   op = ALU_XOR;
            CMD_MULLO: op = ALU_MULTU;
            default:   op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rpn_seq_ctrl.sv
// Sequencing controller: accepts one decoded RPN command at a time and walks
// the stack/ALU through the per-command pop/exec/push micro-sequence, with
// depth tracking for overflow/underflow detection and a completion counter.
module rpn_seq_ctrl #(
    parameter  int DEPTH = 8,
    parameter  int W     = 32,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [15:0]   cmd_val,
    output logic          stk_pop,
    output logic          stk_push,
    output logic [W-1:0]  stk_din,
    input  logic [W-1:0]  stk_top,
    input  logic [W-1:0]  stk_next,
    output logic [3:0]    alu_op,
    output logic [W-1:0]  alu_a,
    output logic [W-1:0]  alu_b,
    output logic [7:0]    alu_shamt,
    input  logic [W-1:0]  alu_lo,
    output logic          done,
    output logic [1:0]    status,
    output logic [DW-1:0] depth,
    output logic [7:0]    op_count
);
    import rpn_pkg::*;

    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_e          state_q;
    rpn_cmd_e        op_q;
    rpn_cmd_e        cmd_s;
    rpn_status_e     status_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    din_q;
    logic [W-1:0]    alu_a_q;
    logic [W-1:0]    alu_b_q;
    logic [3:0]      alu_op_q;
    logic [7:0]      shamt_q;
    logic            ready_q;
    logic            pop_q;
    logic            push_q;
    logic            done_q;
    logic [DW-1:0]   depth_q;
    logic [DW-1:0]   depth_d;
    logic [7:0]      cnt_q;

    assign cmd_s = rpn_cmd_e'(cmd_op);

    // Depth follows the strobes on the same edge the stack commits them.
    always_comb begin
        depth_d = depth_q;
        if (push_q) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_q) begin
            depth_d = depth_q - DW'(1);
        end else begin
            depth_d = depth_q;
        end
    end

    // Command FSM; every output is registered alongside the state transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= CMD_PUSH;
            status_q <= ST_OK;
            a_q      <= '0;
            b_q      <= '0;
            din_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= ALU_ADD;
            shamt_q  <= 8'd0;
            ready_q  <= 1'b1;
            pop_q    <= 1'b0;
            push_q   <= 1'b0;
            done_q   <= 1'b0;
            depth_q  <= '0;
            cnt_q    <= 8'd0;
        end else begin
            pop_q   <= 1'b0;
            push_q  <= 1'b0;
            done_q  <= 1'b0;
            depth_q <= depth_d;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        ready_q <= 1'b0;
                        op_q    <= cmd_s;
                        a_q     <= stk_top;
                        b_q     <= stk_next;
                        case (cmd_s)
                            CMD_PUSH: begin
                                if (depth_q == DEPTH_MAX) begin
                                    state_q  <= S_ERR;
                                    done_q   <= 1'b1;
                                    status_q <= ST_OVF;
                                end else begin
                                    state_q <= S_PUSH1;
                                    push_q  <= 1'b1;
                                    din_q   <= {{(W-16){1'b0}}, cmd_val};
                                end
                            end
                            CMD_POP: begin
                                if (depth_q == DW'(0)) begin
                                    state_q  <= S_ERR;
                                    done_q   <= 1'b1;
                                    status_q <= ST_UNF;
                                end else begin
                                    state_q <= S_POP1;
                                    pop_q   <= 1'b1;
                                end
                            end
                            CMD_ADD, CMD_SUB, CMD_SLL, CMD_SRL, CMD_SLTU,
                            CMD_AND, CMD_OR, CMD_NOR, CMD_XOR, CMD_MULLO,
                            CMD_SWAP: begin
                                if (depth_q < DW'(2)) begin
                                    state_q  <= S_ERR;
                                    done_q   <= 1'b1;
                                    status_q <= ST_UNF;
                                end else begin
                                    state_q <= S_POP1;
                                    pop_q   <= 1'b1;
                                end
                            end
                            default: begin
                                // Unassigned opcode: complete as a no-op, not counted.
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                                status_q <= ST_OK;
                            end
                        endcase
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_POP1: begin
                    if (op_q == CMD_POP) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        status_q <= ST_OK;
                        cnt_q    <= cnt_q + 8'd1;
                    end else begin
                        state_q <= S_POP2;
                        pop_q   <= 1'b1;
                    end
                end
                S_POP2: begin
                    if (op_q == CMD_SWAP) begin
                        state_q <= S_PUSH1;
                        push_q  <= 1'b1;
                        din_q   <= a_q;
                    end else begin
                        // ALU sees a = second-to-top, b = top for the EXEC cycle.
                        state_q  <= S_EXEC;
                        alu_op_q <= cmd_to_aluop(op_q);
                        alu_a_q  <= b_q;
                        alu_b_q  <= a_q;
                        shamt_q  <= {3'b000, a_q[4:0]};
                    end
                end
                S_EXEC: begin
                    // The ALU result is captured straight into the write-data register.
                    state_q <= S_PUSH1;
                    push_q  <= 1'b1;
                    din_q   <= alu_lo;
                end
                S_PUSH1: begin
                    if (op_q == CMD_SWAP) begin
                        state_q <= S_PUSH2;
                        push_q  <= 1'b1;
                        din_q   <= b_q;
                    end else begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        status_q <= ST_OK;
                        cnt_q    <= cnt_q + 8'd1;
                    end
                end
                S_PUSH2: begin
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                    status_q <= ST_OK;
                    cnt_q    <= cnt_q + 8'd1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                S_ERR: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign stk_pop   = pop_q;
    assign stk_push  = push_q;
    assign stk_din   = din_q;
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_shamt = shamt_q;
    assign done      = done_q;
    assign status    = status_q;
    assign depth     = depth_q;
    assign op_count  = cnt_q;

endmodule
